// File: rtl/mul_div_seq_unit.sv
// Multi-cycle RV32M multiply unit with a radix-2 shift-add engine.
// The engine works on operand magnitudes; the sign is reapplied to the full product in DONE.
module mul_div_seq_unit #(
  parameter int         XLEN     = 32,
  parameter logic [4:0] C_MUL    = 5'b01010,
  parameter logic [4:0] C_MULH   = 5'b01011,
  parameter logic [4:0] C_MULHSU = 5'b01100,
  parameter logic [4:0] C_MULHU  = 5'b01101
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [4:0]      alu_control_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_next;
  logic [4:0]        op;
  logic [4:0]        tag;
  logic              neg;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_q;

  logic              code_ok, accept, sa, sb;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   result_sel;

  assign code_ok = (alu_control_i >= C_MUL) && (alu_control_i <= C_MULHU);
  assign accept  = (state == IDLE) && start_i && code_ok && !flush_i;
  assign sa      = src_a_i[XLEN-1] && (alu_control_i != C_MULHU);
  assign sb      = src_b_i[XLEN-1] && ((alu_control_i == C_MUL) || (alu_control_i == C_MULH));
  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign a_abs   = sa ? (~src_a_i + 1'b1) : src_a_i;
  assign b_abs   = sb ? (~src_b_i + 1'b1) : src_b_i;

  assign prod       = neg ? (~acc + 1'b1) : acc;
  assign result_sel = (op == C_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign ready_o  = (state == IDLE);
  assign stall_o  = (state != IDLE);
  assign done_o   = (state == DONE) && !flush_i;
  assign result_o = done_o ? result_sel : result_q;
  assign rd_o     = done_o ? tag : rd_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        if (flush_i)                      state_next = IDLE;
        else if (cnt == CW'(XLEN - 1))    state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= '0;
      tag      <= '0;
      neg      <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      op     <= alu_control_i;
      tag    <= rd_i;
      neg    <= sa ^ sb;
      acc    <= '0;
      mcand  <= {{XLEN{1'b0}}, a_abs};
      mplier <= b_abs;
      cnt    <= '0;
    end else if (state == CALC) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end else if (done_o) begin
      result_q <= result_sel;
      rd_q     <= tag;
    end
  end

endmodule

// File: tb/tb_mul_div_seq_unit.sv
// Scoreboard bench for mul_div_seq_unit: expected results queued at issue, popped on done_o.
module tb_mul_div_seq_unit;

  localparam logic [4:0] C_MUL    = 5'b01010;
  localparam logic [4:0] C_MULH   = 5'b01011;
  localparam logic [4:0] C_MULHSU = 5'b01100;
  localparam logic [4:0] C_MULHU  = 5'b01101;
  localparam int         LAT      = 33;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [4:0]  alu_control_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        ready_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  mul_div_seq_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .alu_control_i(alu_control_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .rd_i(rd_i), .flush_i(flush_i),
    .ready_o(ready_o), .stall_o(stall_o), .done_o(done_o),
    .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] code, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (code == C_MULHU) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (code == C_MUL || code == C_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (code == C_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Called just after a rising edge; waits for ready, drives one request for one cycle.
  task automatic applyStimulus(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] exp, input bit push);
    exp_t e;
    for (int i = 0; i < 100 && !ready_o; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("ready_wait", {63'b0, ready_o}, 64'd1);
    start_i = 1'b1; alu_control_i = code; src_a_i = a; src_b_i = b; rd_i = rd;
    if (push) begin
      e.res = exp; e.rd = rd; e.t = cyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    checkOutput("drain", 64'(q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (q.size() == 0) checkOutput("spurious_done", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        checkOutput("result", {32'b0, result_o}, {32'b0, e.res});
        checkOutput("rd", {59'b0, rd_o}, {59'b0, e.rd});
        checkOutput("latency", 64'(cyc - e.t), 64'(LAT));
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic [4:0]  rc;
    int          s;
    rst = 1'b1; start_i = 1'b0; alu_control_i = '0; src_a_i = '0; src_b_i = '0;
    rd_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {63'b0, ready_o}, 64'd1);
    checkOutput("rst_stall", {63'b0, stall_o}, 64'd0);
    checkOutput("rst_done", {63'b0, done_o}, 64'd0);
    checkOutput("rst_result", {32'b0, result_o}, 64'd0);
    checkOutput("rst_rd", {59'b0, rd_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] T1-T3 directed products");
    applyStimulus(C_MUL, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, 1'b1);
    waitDrain();
    applyStimulus(C_MULH, 32'h80000000, 32'h80000000, 5'd4, 32'h40000000, 1'b1);
    waitDrain();
    applyStimulus(C_MUL, 32'h80000000, 32'h80000000, 5'd5, 32'h00000000, 1'b1);
    waitDrain();
    applyStimulus(C_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFF, 1'b1);
    waitDrain();
    applyStimulus(C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 1'b1);
    waitDrain();
    applyStimulus(C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'h00000001, 1'b1);
    waitDrain();
    applyStimulus(C_MULHU, 32'h0, 32'h12345678, 5'd9, 32'h0, 1'b1);
    waitDrain();

    $display("[TB] random products");
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom;
      rc = C_MUL + 5'($urandom_range(0, 3));
      applyStimulus(rc, ra, rb, 5'($urandom_range(0, 31)), model(rc, ra, rb), 1'b1);
      waitDrain();
    end

    $display("[TB] T4 flush mid-op");
    s = cyc;
    applyStimulus(C_MUL, 32'd5, 32'd6, 5'd10, 32'd30, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    checkOutput("flush_cycle", 64'(cyc - s), 64'd11);
    checkOutput("flush_ready", {63'b0, ready_o}, 64'd1);
    applyStimulus(C_MUL, 32'd3, 32'd4, 5'd11, 32'd12, 1'b1);
    waitDrain();

    $display("[TB] T5 ignored starts");
    start_i = 1'b1; alu_control_i = 5'b00000; src_a_i = 32'd2; src_b_i = 32'd3; rd_i = 5'd12;
    @(posedge clk); #1;
    start_i = 1'b0;
    checkOutput("badcode_ready", {63'b0, ready_o}, 64'd1);
    checkOutput("badcode_stall", {63'b0, stall_o}, 64'd0);
    applyStimulus(C_MUL, 32'd9, 32'd11, 5'd13, 32'd99, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    start_i = 1'b1; alu_control_i = C_MULHU; src_a_i = 32'd2; src_b_i = 32'd3; rd_i = 5'd14;
    @(posedge clk); #1;
    start_i = 1'b0;
    waitDrain();
    repeat (40) @(posedge clk);
    #1;

    $display("[TB] T6 reset mid-op");
    applyStimulus(C_MULH, 32'h12345678, 32'h9ABCDEF0, 5'd15, 32'h0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_ready", {63'b0, ready_o}, 64'd1);
    checkOutput("midrst_stall", {63'b0, stall_o}, 64'd0);
    checkOutput("midrst_result", {32'b0, result_o}, 64'd0);
    checkOutput("midrst_done", {63'b0, done_o}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    applyStimulus(C_MULHSU, 32'hFFFFFFFE, 32'd3, 5'd16, model(C_MULHSU, 32'hFFFFFFFE, 32'd3), 1'b1);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
